boot_fetch: RTL
===============

BOOT_FETCH -- requirements
Module: boot_fetch

Interface
REQ-001 The block SHALL have parameter BOOT_SIZE, default 256, giving the number of valid boot ROM words.
REQ-002 The block SHALL have parameter RUN_START, default 16'h0000, giving the first instruction RAM address after boot.
REQ-003 The block SHALL have parameter NOP, default 16'hEA80 (Hack "0", no dest, no jump), giving the bubble instruction.
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port stall, input, 1 bit: hold PC, state and instruction this cycle.
REQ-007 Port jmp, input, 1 bit: CPU jump request.
REQ-008 Port jmp_addr, input, 16 bits: CPU jump target.
REQ-009 Port boot_done, input, 1 bit: one-cycle pulse from the memory-mapped boot control register.
REQ-010 Port rom_instr, input, 16 bits: boot ROM word at pc, combinational.
REQ-011 Port ram_instr, input, 16 bits: instruction RAM word at pc, combinational.
REQ-012 Port pc, output, 16 bits: fetch address, driven to both boot ROM and instruction RAM.
REQ-013 Port instruction, output, 16 bits: instruction presented to the CPU.
REQ-014 Port boot_mode, output, 1 bit: high while in state BOOT.
REQ-015 Port fault, output, 1 bit: sticky boot address fault flag.

Function
REQ-016 The block SHALL implement states BOOT, FLUSH, RUN, with pc held in a 16-bit register.
REQ-017 In BOOT, instruction SHALL equal rom_instr combinationally, with zero-cycle latency from pc.
REQ-018 In RUN, instruction SHALL equal ram_instr combinationally.
REQ-019 In FLUSH, instruction SHALL equal NOP.
REQ-020 Any cycle with fault=1 SHALL output instruction = NOP.
REQ-021 PC next-value priority SHALL be: reset, then boot_done in BOOT, then stall, then fault, then jmp, then increment.
REQ-022 boot_done=1 in BOOT SHALL load pc=RUN_START and move to FLUSH, regardless of stall or jmp.
REQ-023 FLUSH SHALL last exactly one non-stalled cycle with pc held, then move to RUN; stall in FLUSH SHALL extend FLUSH.
REQ-024 boot_done SHALL be ignored in FLUSH and RUN; no return to BOOT except by reset.
REQ-025 stall=1 SHALL hold pc and state; instruction continues to track the selected source combinationally.
REQ-026 jmp=1 with stall=0 SHALL load pc=jmp_addr on the next edge.
REQ-027 Otherwise, pc SHALL increment by 1 modulo 2^16, so 16'hFFFF wraps to 16'h0000.
REQ-028 In BOOT, when pc >= BOOT_SIZE and stall=0, fault SHALL be set on the next edge.
REQ-029 Once fault is set, pc SHALL hold, jmp SHALL be ignored, and boot_done SHALL still transition to FLUSH.
REQ-030 fault SHALL persist into RUN, clearing only on reset.
REQ-031 A jmp to an address >= BOOT_SIZE in BOOT SHALL be taken and fault on the following cycle.

Reset
REQ-032 reset=1 at a clock edge SHALL force state=BOOT, pc=16'h0000 and fault=0, overriding all other inputs.
REQ-033 Immediately after reset, boot_mode SHALL be 1 and instruction SHALL be rom_instr at address 0.
REQ-034 Reset asserted mid-FLUSH or mid-RUN SHALL return to BOOT on that edge with no residual state.

Verification
REQ-035 Reset, then 5 free cycles with rom_instr=pc -> pc 0,1,2,3,4,5; instruction matches rom_instr; boot_mode=1.
REQ-036 At pc=3, apply jmp=1, jmp_addr=16'h0010 together with stall=1, then release stall -> pc holds 3, then becomes 16'h0010; later 16'h0011.
REQ-037 At pc=7, pulse boot_done with jmp=1 -> next cycle state FLUSH, pc=RUN_START, instruction=16'hEA80; following cycle RUN with instruction=ram_instr; boot_mode=0.
REQ-038 jmp to 16'h00FF in BOOT -> after one increment pc=16'h0100; next cycle fault=1, pc holds 16'h0100, instruction=16'hEA80; fault survives boot_done into RUN.
REQ-039 In RUN, jmp to 16'hFFFF then one free cycle -> pc=16'h0000, no fault.
REQ-040 Assert reset while in RUN with fault=1 -> next cycle pc=0, fault=0, boot_mode=1.

Source files
------------

// File: rtl/boot_fetch.sv
// Boot/run instruction fetch: presents boot ROM words until software signals boot_done,
// inserts one bubble, then fetches from instruction RAM. Out-of-range boot fetches latch a fault.
module boot_fetch #(
    parameter int          BOOT_SIZE = 256,
    parameter logic [15:0] RUN_START = 16'h0000,
    parameter logic [15:0] NOP       = 16'hEA80
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        jmp,
    input  logic [15:0] jmp_addr,
    input  logic        boot_done,
    input  logic [15:0] rom_instr,
    input  logic [15:0] ram_instr,
    output logic [15:0] pc,
    output logic [15:0] instruction,
    output logic        boot_mode,
    output logic        fault
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FLUSH = 2'd1,
        RUN   = 2'd2
    } state_t;

    // One extra bit so a BOOT_SIZE of 65536 still compares correctly.
    localparam logic [16:0] BOOT_LIMIT = 17'(BOOT_SIZE);

    state_t      state, state_nxt;
    logic [15:0] pc_nxt;
    logic        fault_nxt;
    logic        boot_exit;
    logic        boot_oob;

    assign boot_exit = (state == BOOT) && boot_done;
    assign boot_oob  = (state == BOOT) && ({1'b0, pc} >= BOOT_LIMIT) && !stall;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= BOOT;
            pc    <= 16'h0000;
            fault <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            fault <= fault_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            BOOT:    if (boot_done) state_nxt = FLUSH;
            FLUSH:   if (!stall)    state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = BOOT;
        endcase
    end

    // The faulting fetch itself holds pc, so the bad address stays visible.
    always_comb begin
        pc_nxt = pc;
        if (boot_exit)
            pc_nxt = RUN_START;
        else if (stall)
            pc_nxt = pc;
        else if (fault || boot_oob)
            pc_nxt = pc;
        else if (state == FLUSH)
            pc_nxt = pc;
        else if (jmp)
            pc_nxt = jmp_addr;
        else
            pc_nxt = pc + 16'd1;
    end

    always_comb begin
        fault_nxt = fault | boot_oob;
    end

    // Output logic
    always_comb begin
        boot_mode   = (state == BOOT);
        instruction = NOP;
        if (!fault) begin
            case (state)
                BOOT:    instruction = rom_instr;
                RUN:     instruction = ram_instr;
                default: instruction = NOP;
            endcase
        end
    end

endmodule
